polyunit_host_seq: RTL and testbench

- Host-side sequencer that drives the Kyber poly unit core.
- Accepts a command (mode), then streams NCOEF coefficients in and writes them into the core's input port.
- Pulses run, waits for done, then reads NCOEF results back through the core's output address/data port and streams them out.
- Sits between the system bus/DMA stream and the poly unit; it is the initiator for the poly unit's run/done interface.

---
 rtl/polyunit_host_seq.sv | 212 +++++++++++++++++++++
 tb/tb_polyunit_host_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyunit_host_seq.sv
// Host-side sequencer for the Kyber poly unit: load NCOEF coefficients, pulse run, wait for done, stream results out.
// Optional WAIT watchdog is built when POLYUNIT_HOST_TIMEOUT_EN is defined.
module polyunit_host_seq #(
    parameter int DATWID      = 12,
    parameter int ADDWID      = 7,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATWID-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATWID-1:0] m_data,
    output logic              m_last,
    output logic [DATWID-1:0] pu_data_in,
    output logic [ADDWID-1:0] pu_add_in,
    output logic              pu_we,
    output logic [ADDWID-1:0] pu_add_out,
    input  logic [DATWID-1:0] pu_data_out,
    output logic [1:0]        pu_mode,
    output logic              pu_run,
    input  logic              pu_done,
    output logic              busy,
    output logic              err
);
    localparam int              CNTW        = ADDWID + 1;
    localparam logic [CNTW-1:0] LAST_IDX    = CNTW'((1 << ADDWID) - 1);
    localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);
    localparam logic [1:0]      MODE_DATAIN = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_UNLOAD,
        ST_FIN
    } state_t;

    state_t            state_q;
    logic              cmd_ready_q;
    logic              s_ready_q;
    logic              pu_we_q;
    logic              pu_run_q;
    logic [1:0]        pu_mode_q;
    logic [DATWID-1:0] pu_data_in_q;
    logic [ADDWID-1:0] pu_add_in_q;
    logic [CNTW-1:0]   wr_cnt_q;
    logic [CNTW-1:0]   rd_cnt_q;
    logic [CNTW-1:0]   out_cnt_q;
    logic              inflight_q;
    logic [DATWID-1:0] fifo_mem_q [2];
    logic              fifo_wptr_q;
    logic              fifo_rptr_q;
    logic [1:0]        fifo_cnt_q;

    logic              cmd_fire;
    logic              s_fire;
    logic              m_fire;
    logic              read_issue;
    logic [1:0]        fifo_after_pop;
    logic [1:0]        fifo_cnt_d;

`ifdef POLYUNIT_HOST_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_q;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_fire = cmd_valid & cmd_ready_q;
    assign s_fire   = s_valid & s_ready_q;
    assign m_fire   = m_valid & m_ready;

    // Read budget counts the slot freed by a same-cycle pop, which is what lets a
    // 2-entry FIFO plus one outstanding read sustain one beat per cycle.
    assign fifo_after_pop = fifo_cnt_q - {1'b0, m_fire};
    assign fifo_cnt_d     = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, m_fire};
    assign read_issue     = (state_q == ST_UNLOAD) && (rd_cnt_q <= LAST_IDX) &&
                            ((fifo_after_pop + {1'b0, inflight_q}) < 2'd2);

    assign cmd_ready  = cmd_ready_q;
    assign s_ready    = s_ready_q;
    assign m_valid    = (fifo_cnt_q != 2'd0);
    assign m_data     = fifo_mem_q[fifo_rptr_q];
    assign m_last     = m_valid && (out_cnt_q == LAST_IDX);
    assign pu_data_in = pu_data_in_q;
    assign pu_add_in  = pu_add_in_q;
    assign pu_we      = pu_we_q;
    assign pu_add_out = rd_cnt_q[ADDWID-1:0];
    assign pu_mode    = pu_mode_q;
    assign pu_run     = pu_run_q;
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            s_ready_q     <= 1'b0;
            pu_we_q       <= 1'b0;
            pu_run_q      <= 1'b0;
            pu_mode_q     <= 2'd0;
            pu_data_in_q  <= '0;
            pu_add_in_q   <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            out_cnt_q     <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wptr_q   <= 1'b0;
            fifo_rptr_q   <= 1'b0;
            fifo_cnt_q    <= 2'd0;
`ifdef POLYUNIT_HOST_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            pu_we_q  <= 1'b0;
            pu_run_q <= 1'b0;

            // Read pipeline: the core answers one cycle after the address, so the
            // inflight flag marks exactly which cycle's pu_data_out to capture.
            inflight_q <= read_issue;
            if (read_issue) begin
                rd_cnt_q <= rd_cnt_q + CNT_ONE;
            end
            if (inflight_q) begin
                fifo_mem_q[fifo_wptr_q] <= pu_data_out;
                fifo_wptr_q             <= ~fifo_wptr_q;
            end
            if (m_fire) begin
                fifo_rptr_q <= ~fifo_rptr_q;
                out_cnt_q   <= out_cnt_q + CNT_ONE;
            end
            fifo_cnt_q <= fifo_cnt_d;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        state_q     <= ST_LOAD;
                        pu_mode_q   <= cmd_mode;
                        wr_cnt_q    <= '0;
                        cmd_ready_q <= 1'b0;
                        s_ready_q   <= 1'b1;
`ifdef POLYUNIT_HOST_TIMEOUT_EN
                        tmo_cnt_q   <= '0;
                        err_q       <= 1'b0;
`endif
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (s_fire) begin
                        pu_we_q      <= 1'b1;
                        pu_add_in_q  <= wr_cnt_q[ADDWID-1:0];
                        pu_data_in_q <= s_data;
                        wr_cnt_q     <= wr_cnt_q + CNT_ONE;
                        if (wr_cnt_q == LAST_IDX) begin
                            s_ready_q <= 1'b0;
                            state_q   <= (pu_mode_q == MODE_DATAIN) ? ST_FIN : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    pu_run_q <= 1'b1;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pu_done) begin
                        state_q   <= ST_UNLOAD;
                        rd_cnt_q  <= '0;
                        out_cnt_q <= '0;
                    end
`ifdef POLYUNIT_HOST_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_q <= ST_FIN;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                    end
`endif
                end
                ST_UNLOAD: begin
                    if (m_fire && (out_cnt_q == LAST_IDX)) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polyunit_host_seq.sv
// Randomised bench for polyunit_host_seq with a behavioural poly-unit core and a queue-based reference.
// The watchdog scenario is exercised only when POLYUNIT_HOST_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_polyunit_host_seq;
    localparam int NCOEF   = 128;
    localparam int TMO_CYC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [11:0] m_data;
    logic        m_last;
    logic [11:0] pu_data_in;
    logic [6:0]  pu_add_in;
    logic        pu_we;
    logic [6:0]  pu_add_out;
    logic [11:0] pu_data_out = '0;
    logic [1:0]  pu_mode;
    logic        pu_run;
    logic        pu_done;
    logic        busy;
    logic        err;

    polyunit_host_seq #(.DATWID(12), .ADDWID(7), .TIMEOUT_CYC(TMO_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .pu_data_in(pu_data_in), .pu_add_in(pu_add_in), .pu_we(pu_we),
        .pu_add_out(pu_add_out), .pu_data_out(pu_data_out),
        .pu_mode(pu_mode), .pu_run(pu_run), .pu_done(pu_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int passCount = 0;
    int checkCount = 0;
    int cycle = 0;
    int coreOffset = 100;
    int doneDelay = 20;
    bit doneEnable = 1'b1;
    int readyMode = 0;
    logic manualDone = 1'b0;
    logic autoDone = 1'b0;
    int doneTimer = 0;

    logic [11:0] loadData [NCOEF];
    logic [6:0]  weAddr[$];
    logic [11:0] weData[$];
    logic [1:0]  runMode[$];
    logic [11:0] outData[$];
    logic        outLast[$];
    int runCount, runCycle, lastLoadCycle, autoDoneCycle, firstValidCycle;
    int firstPopCycle, lastPopCycle, idleCycle;
    bit holdPending = 1'b0;
    logic [11:0] heldData = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    endtask

    function automatic logic [11:0] coreFn(input int addr);
        logic [11:0] v;
        v = 12'(addr + coreOffset);
        return v;
    endfunction

    // Behavioural core: synchronous read port, done pulse doneDelay cycles after run.
    always @(posedge clk) begin
        pu_data_out <= coreFn(int'(pu_add_out));
        if (rst) begin
            doneTimer <= 0;
            autoDone  <= 1'b0;
        end else begin
            if (pu_run && doneEnable) doneTimer <= doneDelay;
            else if (doneTimer > 0) doneTimer <= doneTimer - 1;
            autoDone <= (doneTimer == 2);
        end
    end
    assign pu_done = autoDone | manualDone;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        #1;
        case (readyMode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Observe the DUT mid-cycle; handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            holdPending = 1'b0;
        end else begin
            if (pu_we) begin
                weAddr.push_back(pu_add_in);
                weData.push_back(pu_data_in);
            end
            if (pu_run) begin
                runCount++;
                runMode.push_back(pu_mode);
                runCycle = cycle;
            end
            if (s_valid && s_ready) lastLoadCycle = cycle;
            if (autoDone) autoDoneCycle = cycle;
            if (m_valid && firstValidCycle < 0) firstValidCycle = cycle;
            if (holdPending) begin
                checkOutput("m_hold_valid", m_valid, 1);
                checkOutput("m_hold_data", m_data, heldData);
            end
            if (m_valid && m_ready) begin
                outData.push_back(m_data);
                outLast.push_back(m_last);
                if (firstPopCycle < 0) firstPopCycle = cycle;
                lastPopCycle = cycle;
            end
            holdPending = m_valid && !m_ready;
            heldData    = m_data;
        end
    end

    task automatic clearLogs();
        weAddr.delete(); weData.delete(); runMode.delete();
        outData.delete(); outLast.delete();
        runCount = 0; runCycle = -1; lastLoadCycle = -1; autoDoneCycle = -1;
        firstValidCycle = -1; firstPopCycle = -1; lastPopCycle = -1;
    endtask

    // Issue one command and stream NCOEF beats; entered and left just after a rising edge.
    task automatic applyStimulus(input logic [1:0] mode, input int gapPct, input bit ramp, input int earlyDoneBeat);
        int guard = 0;
        int idx = 0;
        bit pulsed = 1'b0;
        clearLogs();
        for (int i = 0; i < NCOEF; i++)
            loadData[i] = ramp ? 12'(i * 3) : 12'($urandom_range(0, 4095));
        cmd_mode  = mode;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (!cmd_ready && guard < 100);
        checkOutput("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        guard = 0;
        while (idx < NCOEF && guard < 5000) begin
            s_valid    = ($urandom_range(0, 99) >= gapPct);
            s_data     = loadData[idx];
            manualDone = (!pulsed && idx == earlyDoneBeat);
            if (manualDone) pulsed = 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        s_valid    = 1'b0;
        manualDone = 1'b0;
        checkOutput("load_beats", idx, NCOEF);
    endtask

    task automatic waitIdle(input int maxCycles);
        int guard = 0;
        while (busy && guard < maxCycles) begin
            @(negedge clk);
            guard++;
        end
        idleCycle = cycle;
        checkOutput("idle_reached", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic checkResults(input logic [1:0] mode, input bit burst);
        int nOut;
        checkOutput("we_count", weAddr.size(), NCOEF);
        for (int i = 0; i < weAddr.size() && i < NCOEF; i++) begin
            checkOutput($sformatf("we_addr[%0d]", i), weAddr[i], i);
            checkOutput($sformatf("we_data[%0d]", i), weData[i], loadData[i]);
        end
        checkOutput("run_count", runCount, (mode == 2'd0) ? 0 : 1);
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        checkOutput("pu_mode_held", pu_mode, mode);
        nOut = (mode == 2'd0) ? 0 : NCOEF;
        checkOutput("out_count", outData.size(), nOut);
        if (mode == 2'd0) begin
            checkOutput("no_m_valid", firstValidCycle, -1);
        end else begin
            if (runMode.size() > 0) checkOutput("run_mode", runMode[0], mode);
            checkOutput("run_latency", runCycle - lastLoadCycle, 2);
            checkOutput("unload_after_done", (firstValidCycle > autoDoneCycle) && (autoDoneCycle > runCycle), 1);
            for (int i = 0; i < outData.size() && i < NCOEF; i++) begin
                checkOutput($sformatf("m_data[%0d]", i), outData[i], coreFn(i));
                checkOutput($sformatf("m_last[%0d]", i), outLast[i], (i == NCOEF - 1));
            end
            if (burst) checkOutput("burst_span", lastPopCycle - firstPopCycle, NCOEF - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int guard;
        clearLogs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_pu_we", pu_we, 0);
        checkOutput("rst_pu_run", pu_run, 0);
        checkOutput("rst_pu_mode", pu_mode, 0);
        checkOutput("rst_pu_add_out", pu_add_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("cmd_ready_after_rst", cmd_ready, 1);

        $display("[TB] DATAIN load with ramp data");
        readyMode = 0;
        applyStimulus(2'd0, 0, 1'b1, -1);
        waitIdle(200);
        checkResults(2'd0, 1'b0);

        $display("[TB] NTT with data = addr+100, m_ready held high");
        coreOffset = 100;
        applyStimulus(2'd1, 0, 1'b0, -1);
        waitIdle(1000);
        checkResults(2'd1, 1'b1);

        $display("[TB] NTT with toggling m_ready and gapped input");
        readyMode  = 1;
        coreOffset = int'($urandom_range(0, 4095));
        applyStimulus(2'd1, 30, 1'b0, -1);
        waitIdle(2000);
        checkResults(2'd1, 1'b0);

        $display("[TB] reset during unload, then INTT");
        readyMode = 2;
        applyStimulus(2'd1, 10, 1'b0, -1);
        guard = 0;
        while (outData.size() < 50 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_reached_beat50", outData.size() >= 50, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_m_valid", m_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pu_we", pu_we, 0);
        checkOutput("abort_pu_run", pu_run, 0);
        @(posedge clk); #1;
        coreOffset = int'($urandom_range(0, 4095));
        applyStimulus(2'd2, 20, 1'b0, -1);
        waitIdle(2000);
        checkResults(2'd2, 1'b0);

        $display("[TB] pu_done pulsed during load is ignored");
        readyMode = 0;
        applyStimulus(2'd1, 10, 1'b0, 60);
        waitIdle(1000);
        checkResults(2'd1, 1'b1);

`ifdef POLYUNIT_HOST_TIMEOUT_EN
        $display("[TB] watchdog with pu_done withheld");
        doneEnable = 1'b0;
        applyStimulus(2'd1, 0, 1'b0, -1);
        waitIdle(500);
        checkOutput("tmo_err", err, 1);
        checkOutput("tmo_no_m_valid", firstValidCycle, -1);
        checkOutput("tmo_fin_timing", idleCycle - runCycle, TMO_CYC + 1);
        doneEnable = 1'b1;
        applyStimulus(2'd3, 0, 1'b0, -1);
        checkOutput("tmo_err_cleared", err, 0);
        waitIdle(1000);
        checkResults(2'd3, 1'b1);
`endif

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
